watch_time_counter: RTL and testbench

Time-of-day counter for the IC watch. Keeps hours, minutes and seconds in packed BCD, advancing once per `clk1hz` edge. Supports a set mode in which the user steps minutes and hours with debounced single-cycle button pulses. Its `hour`/`min` outputs feed the alarm comparator and the display driver directly.

---
 rtl/watch_time_counter.sv | 104 ++++++++++
 tb/tb_watch_time_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/watch_time_counter.sv
// Time-of-day counter for the watch: packed-BCD hours/minutes/seconds advanced
// on every clk1hz edge, with a SET mode for stepping minutes and hours.
module watch_time_counter #(
  parameter logic [7:0] RESET_HOUR = 8'h12,
  parameter logic [7:0] RESET_MIN  = 8'h00
) (
  input  logic       clk1hz,
  input  logic       rst,
  input  logic       set_time,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       min_tick,
  output logic       state_dbg
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       tick_q, tick_d;

  // BCD increment for 00..59 fields; 59 wraps to 00.
  function automatic logic [7:0] bcd_inc_60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD increment for hours; only 23 wraps, 19 -> 20 is an ordinary tens carry.
  function automatic logic [7:0] bcd_inc_24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // The mode applied on an edge is the level of set_time at that edge, so a
  // rollover coinciding with set_time rising is handled as SET.
  always_comb begin
    state_d = set_time ? ST_SET : ST_RUN;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    if (set_time) begin
      sec_d = 8'h00;
      if (inc_min) begin
        min_d = bcd_inc_60(min_q);
      end
      if (inc_hour) begin
        hour_d = bcd_inc_24(hour_q);
      end
    end else begin
      sec_d = bcd_inc_60(sec_q);
      if (sec_q == 8'h59) begin
        min_d  = bcd_inc_60(min_q);
        tick_d = 1'b1;
        if (min_q == 8'h59) begin
          hour_d = bcd_inc_24(hour_q);
        end
      end
    end
  end

  always_ff @(posedge clk1hz) begin
    if (rst) begin
      state_q <= ST_RUN;
      hour_q  <= RESET_HOUR;
      min_q   <= RESET_MIN;
      sec_q   <= 8'h00;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
    end
  end

  assign hour      = hour_q;
  assign min       = min_q;
  assign sec       = sec_q;
  assign min_tick  = tick_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Bench for watch_time_counter: directed time-setting scenarios plus random
// mode/pulse/reset traffic, compared against a decimal time-of-day model.
module tb_watch_time_counter;

  localparam logic [7:0] RH = 8'h12;
  localparam logic [7:0] RM = 8'h00;

  logic       clk1hz = 1'b0;
  logic       rst = 1'b1;
  logic       set_time = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic [7:0] hour, min, sec;
  logic       min_tick, state_dbg;

  int errors = 0;
  int checks = 0;

  // Reference model held as plain decimal numbers.
  int m_h, m_m, m_s, m_tick, m_st;

  watch_time_counter #(.RESET_HOUR(RH), .RESET_MIN(RM)) dut (
    .clk1hz    (clk1hz),
    .rst       (rst),
    .set_time  (set_time),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
    .hour      (hour),
    .min       (min),
    .sec       (sec),
    .min_tick  (min_tick),
    .state_dbg (state_dbg)
  );

  always #5 clk1hz = ~clk1hz;

  function automatic int bcd2dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] dec2bcd(input int d);
    logic [7:0] r;
    r[7:4] = 4'(d / 10);
    r[3:0] = 4'(d % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t, model %0d:%0d:%0d)",
               tag, obs, exp, $time, m_h, m_m, m_s);
    end
  endtask

  task automatic model_edge(input bit r, input bit st, input bit im, input bit ih);
    if (r) begin
      m_h = bcd2dec(RH); m_m = bcd2dec(RM); m_s = 0; m_tick = 0; m_st = 0;
    end else if (st) begin
      m_s = 0; m_tick = 0; m_st = 1;
      if (im) m_m = (m_m + 1) % 60;
      if (ih) m_h = (m_h + 1) % 24;
    end else begin
      m_st = 0; m_tick = 0;
      m_s = m_s + 1;
      if (m_s == 60) begin
        m_s = 0; m_tick = 1;
        m_m = m_m + 1;
        if (m_m == 60) begin
          m_m = 0;
          m_h = (m_h + 1) % 24;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("hour", 32'(hour), 32'(dec2bcd(m_h)));
    check("min", 32'(min), 32'(dec2bcd(m_m)));
    check("sec", 32'(sec), 32'(dec2bcd(m_s)));
    check("min_tick", 32'(min_tick), 32'(m_tick));
    check("state", 32'(state_dbg), 32'(m_st));
  endtask

  // One clock edge: drive on the falling edge, update model on the rising
  // edge, compare shortly after.
  task automatic step(input bit r, input bit st, input bit im, input bit ih);
    @(negedge clk1hz);
    rst = r; set_time = st; inc_min = im; inc_hour = ih;
    @(posedge clk1hz);
    model_edge(r, st, im, ih);
    #1;
    compare_all();
  endtask

  task automatic run_edges(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Walk to a target time in SET mode; seconds end at 00.
  task automatic set_to(input int th, input int tm);
    int guard;
    guard = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    while ((m_h != th || m_m != tm) && guard < 200) begin
      step(1'b0, 1'b1, m_m != tm, m_h != th);
      guard++;
    end
    check("set_to_reached", 32'(m_h * 100 + m_m), 32'(th * 100 + tm));
  endtask

  initial begin
    int tick_count;
    m_h = 0; m_m = 0; m_s = 0; m_tick = 0; m_st = 0;

    // Reset state and first RUN seconds.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_hour_12", 32'(hour), 32'h12);
    check("reset_sec_00", 32'(sec), 32'h00);
    run_edges(5);
    check("sec_after_5", 32'(sec), 32'h05);

    // 23:59 preload, then 60 RUN edges wraps the whole day.
    set_to(23, 59);
    tick_count = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tick_count += int'(min_tick);
    end
    check("day_wrap_time", {8'h0, hour, min, sec}, 32'h0000_0000);
    check("day_wrap_tick", 32'(min_tick), 32'd1);
    check("day_wrap_tick_count", 32'(tick_count), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("tick_one_cycle", 32'(min_tick), 32'd0);

    // BCD tens carries.
    set_to(9, 9);
    run_edges(60);
    check("t_09_10_00", {8'h0, hour, min, sec}, 32'h0009_1000);
    set_to(19, 59);
    run_edges(60);
    check("t_20_00_00", {8'h0, hour, min, sec}, 32'h0020_0000);

    // SET-mode minute wrap without hour carry, and double pulse at 23:xx.
    set_to(7, 59);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("set_min_wrap", {8'h0, hour, min, sec}, 32'h0007_0000);
    set_to(23, 30);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("set_both", {16'h0, hour, min}, 32'h0000_0031);

    // Pulses in RUN mode are ignored.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("run_ignore", {8'h0, hour, min, sec}, 32'h0000_3101);

    // Reset mid-SET with set_time held.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_in_set", {8'h0, hour, min, sec}, 32'h0012_0000);
    check("rst_in_set_state", 32'(state_dbg), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("set_reentered", 32'(state_dbg), 32'd1);
    run_edges(3);
    check("resume_count", 32'(sec), 32'h03);

    // Rollover edge coinciding with set_time rising is treated as SET.
    set_to(10, 59);
    run_edges(59);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("rollover_as_set", {8'h0, hour, min, sec}, 32'h0010_5900);

    // Random traffic, mostly RUN so rollovers occur.
    for (int i = 0; i < 4000; i++) begin
      bit r, st, im, ih;
      r  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 9) == 0);
      im = ($urandom_range(0, 2) == 0);
      ih = ($urandom_range(0, 2) == 0);
      step(r, st, im, ih);
    end
    // Dense SET stepping to exercise hour and minute wraps.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    run_edges(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
